// File: rtl/symbol_packer_pkg.sv
// -----------------------------------------------------------------------------
// symbol_packer_pkg
//   Shared definitions for symbol_packer:
//     SYM_W_DEF / OUT_W_DEF : default symbol and packed-word widths
//     state_e               : packer state (FILL, FULL, FLUSH)
//     cnt_width()           : width of the fill counter for a given geometry
//     CNT_W_DEF             : fill-counter width at the default geometry
// -----------------------------------------------------------------------------
package symbol_packer_pkg;

  localparam int SYM_W_DEF = 3;
  localparam int OUT_W_DEF = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,  // collecting symbols, no flush requested
    FULL  = 2'd1,  // a complete word is waiting for the consumer
    FLUSH = 2'd2   // draining a partial word on request
  } state_e;

  // The counter must hold values up to OUT_W+SYM_W-1.
  function automatic int cnt_width(input int sym_w, input int out_w);
    return $clog2(out_w + sym_w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(SYM_W_DEF, OUT_W_DEF);

endpackage

// File: rtl/symbol_packer.sv
// -----------------------------------------------------------------------------
// symbol_packer
//   Packs SYM_W-bit code symbols from the 4-to-3 encoder stage into OUT_W-bit
//   words, LSB-first. A flush request emits any partial word zero-padded.
//   Input accept and output transfer are mutually exclusive by construction.
//
// Parameters
//   SYM_W      width of one incoming symbol {d2,d1,d0}
//   OUT_W      width of one packed output word (OUT_W >= SYM_W)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_sym carries a valid symbol
//   in_sym     encoder code word
//   in_ready   packer accepts in_sym this cycle
//   flush      single-cycle request to emit a partial word
//   out_valid  out_data holds a packed word
//   out_data   packed word, LSB-first
//   out_ready  consumer takes out_data this cycle
//   out_par    even parity of out_data (only with SYMBOL_PACKER_PARITY_EN)
//
// Configuration
//   SYMBOL_PACKER_PARITY_EN  defined: adds the out_par output.
// -----------------------------------------------------------------------------
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready
`ifdef SYMBOL_PACKER_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int ACC_W = OUT_W + SYM_W - 1;
  localparam int CNT_W = cnt_width(SYM_W, OUT_W);
  localparam logic [CNT_W-1:0] CNT_OUT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_SYM = CNT_W'(SYM_W);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;
  state_e           r_state;

  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_xfer;

  // The state register encodes exactly the handshake conditions:
  // FILL <=> cnt < OUT_W && !flush_pend, and FLUSH always has cnt > 0,
  // so both handshake outputs come straight from flops.
  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == FULL) || (r_state == FLUSH);
  assign out_data  = r_acc[OUT_W-1:0];

`ifdef SYMBOL_PACKER_PARITY_EN
  assign out_par = ^out_data;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid && out_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;

    if (w_accept) begin
      // Accept only happens with cnt < OUT_W, so the symbol always lands
      // inside the OUT_W+SYM_W-1 bit accumulator.
      w_acc_nxt = r_acc | (ACC_W'(in_sym) << r_cnt);
      w_cnt_nxt = r_cnt + CNT_SYM;
    end else if (w_xfer) begin
      // Right shift brings in zeros, keeping unfilled bits clear so a
      // flushed partial word is naturally zero-padded.
      w_acc_nxt = r_acc >> OUT_W;
      w_cnt_nxt = (r_cnt >= CNT_OUT) ? (r_cnt - CNT_OUT) : '0;
    end

    // A flush applies after a same-cycle accept; it is ignored when nothing
    // is buffered or when a flush is already pending.
    if (r_flush_pend) begin
      w_pend_nxt = !(w_xfer && (w_cnt_nxt == '0));
    end else begin
      w_pend_nxt = flush && (w_cnt_nxt != '0);
    end

    if (w_pend_nxt) begin
      w_state_nxt = FLUSH;
    end else if (w_cnt_nxt >= CNT_OUT) begin
      w_state_nxt = FULL;
    end else begin
      w_state_nxt = FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_state      <= FILL;
    end else begin
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_pend <= w_pend_nxt;
      r_state      <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
// -----------------------------------------------------------------------------
// tb_symbol_packer
//   Directed self-checking bench for symbol_packer at default widths.
// -----------------------------------------------------------------------------
module tb_symbol_packer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_sym;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef SYMBOL_PACKER_PARITY_EN
  logic       out_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  symbol_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef SYMBOL_PACKER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges, releases on a falling edge, and returns
  // 1 time unit after a rising edge (the bench's drive/sample point).
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offers one symbol (optionally with flush) and waits for its accept.
  task automatic send(input logic [2:0] s, input logic f);
    int i;
    for (i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_sym   = s;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Takes one word; ok=0 if none appeared within the cycle budget.
  task automatic recv(output logic [7:0] d, output bit ok);
    int i;
    out_ready = 1'b1;
    for (i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    ok = out_valid;
    d  = out_data;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_bad++; $display("FAIL rst_out_data: got %h want 00", out_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready);
    end
    n_cmp++;
    if (dut.r_cnt !== 4'd0) begin
      n_bad++; $display("FAIL rst_cnt: got %0d want 0", dut.r_cnt);
    end
  endtask

  task automatic test_packing();
    logic [7:0] d;
    bit ok;
    do_reset();
    send(3'b101, 1'b0);
    send(3'b011, 1'b0);
    send(3'b110, 1'b0);
    // Word completes on the third accept edge: out_valid one cycle later.
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL pack_latency: out_valid=%0b want 1", out_valid);
    end
`ifdef SYMBOL_PACKER_PARITY_EN
    n_cmp++;
    if (out_par !== 1'b1) begin
      n_bad++; $display("FAIL pack_parity_9d: got %0b want 1", out_par);
    end
`endif
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h9D) begin
      n_bad++; $display("FAIL pack_word: got %h (valid %0b) want 9d", d, ok);
    end
    n_cmp++;
    if (dut.r_cnt !== 4'd1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pack_cnt: cnt=%0d out_valid=%0b want 1/0", dut.r_cnt, out_valid);
    end
    pulse_flush();
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h01) begin
      n_bad++; $display("FAIL pack_flush_word: got %h (valid %0b) want 01", d, ok);
    end
    n_cmp++;
    if (dut.r_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pack_flush_done: cnt=%0d ov=%0b ir=%0b want 0/0/1",
               dut.r_cnt, out_valid, in_ready);
    end
  endtask

  task automatic test_throughput();
    int sent  = 0;
    int words = 0;
    int bad_words = 0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        words++;
        if (out_data !== 8'hFF) bad_words++;
`ifdef SYMBOL_PACKER_PARITY_EN
        n_cmp++;
        if (out_par !== 1'b0) begin
          n_bad++; $display("FAIL tput_parity_ff: got %0b want 0", out_par);
        end
`endif
      end
      if (in_ready && sent < 8) begin
        in_valid = 1'b1;
        in_sym   = 3'b111;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (words != 3 || bad_words != 0) begin
      n_bad++;
      $display("FAIL tput_words: got %0d words (%0d not ff) want 3 ff", words, bad_words);
    end
    n_cmp++;
    if (dut.r_cnt !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL tput_final: cnt=%0d out_valid=%0b want 0/0", dut.r_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    logic [7:0] d;
    bit ok;
    do_reset();
    send(3'b101, 1'b0);
    send(3'b011, 1'b0);
    send(3'b110, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;  // offered symbol must not be taken while stalled
      in_sym   = 3'b111;
      if (out_valid !== 1'b1 || out_data !== 8'h9D || in_ready !== 1'b0) unstable++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (unstable != 0) begin
      n_bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", unstable);
    end
    n_cmp++;
    if (out_data !== 8'h9D || dut.r_cnt !== 4'd9) begin
      n_bad++;
      $display("FAIL bp_held: data=%h cnt=%0d want 9d/9", out_data, dut.r_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || dut.r_cnt !== 4'd1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_transfer: ov=%0b cnt=%0d ir=%0b want 0/1/1",
               out_valid, dut.r_cnt, in_ready);
    end
    pulse_flush();
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h01) begin
      n_bad++; $display("FAIL bp_flush_word: got %h (valid %0b) want 01", d, ok);
    end
  endtask

  task automatic test_flush_corners();
    int spurious = 0;
    logic [7:0] d;
    bit ok;
    do_reset();
    pulse_flush();
    for (int c = 0; c < 3; c++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++; $display("FAIL flush_empty: %0d cycles with output want 0", spurious);
    end
    send(3'b010, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_same_cycle: ov=%0b ir=%0b want 1/0", out_valid, in_ready);
    end
    // A second flush while one is pending must change nothing.
    pulse_flush();
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h02) begin
      n_bad++; $display("FAIL flush_word: got %h (valid %0b) want 02", d, ok);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || dut.r_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_after: ov=%0b cnt=%0d ir=%0b want 0/0/1",
               out_valid, dut.r_cnt, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    bit ok;
    do_reset();
    send(3'b111, 1'b0);
    send(3'b111, 1'b0);
    n_cmp++;
    if (dut.r_cnt !== 4'd6) begin
      n_bad++; $display("FAIL mrst_pre_cnt: got %0d want 6", dut.r_cnt);
    end
    #2;  // away from any clock edge: reset must act asynchronously
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || dut.r_cnt !== 4'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mrst_async: ov=%0b cnt=%0d data=%h ir=%0b want 0/0/00/1",
               out_valid, dut.r_cnt, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'b001, 1'b0);
    send(3'b001, 1'b0);
    send(3'b001, 1'b0);
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h49) begin
      n_bad++; $display("FAIL mrst_word: got %h (valid %0b) want 49", d, ok);
    end
    pulse_flush();
    recv(d, ok);
    n_cmp++;
    if (!ok || d !== 8'h00) begin
      n_bad++; $display("FAIL mrst_flush_word: got %h (valid %0b) want 00", d, ok);
    end
    n_cmp++;
    if (dut.r_cnt !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_final: cnt=%0d ov=%0b want 0/0", dut.r_cnt, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_throughput();
    test_backpressure();
    test_flush_corners();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
